// File: rtl/bram_arbiter.sv
// bram_arbiter: two-requester (Wishbone / accelerator) sequencer for a fixed-latency BRAM; define BRAM_ARB_RR_EN for round-robin ties
module bram_arbiter #(
    parameter int          DELAYS    = 1,
    parameter logic [11:0] ADDR_BASE = 12'h380
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        acc_req_i,
    input  logic        acc_we_i,
    input  logic [3:0]  acc_sel_i,
    input  logic [31:0] acc_adr_i,
    input  logic [31:0] acc_dat_i,
    output logic        acc_ack_o,
    output logic [31:0] acc_dat_o,
    output logic        bram_en_o,
    output logic [3:0]  bram_we_o,
    output logic [31:0] bram_adr_o,
    output logic [31:0] bram_dat_o,
    input  logic [31:0] bram_dat_i,
    output logic [1:0]  grant_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [1:0]  grant_r;
    logic [3:0]  we_r;
    logic [31:0] adr_r, wdat_r, rdata_r;
    logic        wb_req, start, wb_win, last_cyc;
    assign wb_req   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20] == ADDR_BASE);
    assign start    = wb_req | acc_req_i;
    assign last_cyc = cnt == 4'(DELAYS - 1);
`ifdef BRAM_ARB_RR_EN
    logic last_acc;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) last_acc <= 1'b1;
        else if (state == ACK) last_acc <= grant_r[1];
    end
    // on a tie the requester not served last wins
    assign wb_win = wb_req & (~acc_req_i | last_acc);
`else
    assign wb_win = wb_req;
`endif
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE)   ? (start ? ACCESS : IDLE) :
                    (state == ACCESS) ? (last_cyc ? ACK : ACCESS) : IDLE;
    end
    // command registers hold the winner's request for the whole access
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt     <= '0;
            grant_r <= '0;
            we_r    <= '0;
            adr_r   <= '0;
            wdat_r  <= '0;
            rdata_r <= '0;
        end else if (state == IDLE && start) begin
            cnt     <= '0;
            grant_r <= wb_win ? 2'b01 : 2'b10;
            adr_r   <= wb_win ? wbs_adr_i : acc_adr_i;
            wdat_r  <= wb_win ? wbs_dat_i : acc_dat_i;
            we_r    <= wb_win ? (wbs_sel_i & {4{wbs_we_i}}) : (acc_sel_i & {4{acc_we_i}});
        end else if (state == ACCESS) begin
            cnt <= last_cyc ? '0 : cnt + 4'd1;
            if (last_cyc) rdata_r <= bram_dat_i;
        end else if (state == ACK) begin
            grant_r <= '0;
        end
    end
    assign bram_en_o  = state == ACCESS;
    assign bram_we_o  = bram_en_o ? we_r : 4'b0;
    assign bram_adr_o = adr_r;
    assign bram_dat_o = wdat_r;
    assign grant_o    = grant_r;
    // an aborted Wishbone cycle still completes in BRAM but is never acked
    assign wbs_ack_o  = (state == ACK) & grant_r[0] & wbs_cyc_i;
    assign acc_ack_o  = (state == ACK) & grant_r[1];
    assign wbs_dat_o  = rdata_r;
    assign acc_dat_o  = rdata_r;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed bench for bram_arbiter with DELAYS=1 and DELAYS=3 instances
module tb_bram_arbiter;
    logic        clk, rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        wack;
    logic [31:0] wdat_o;
    logic        acc_req, acc_we;
    logic [3:0]  acc_sel;
    logic [31:0] acc_adr, acc_dat;
    logic        aack;
    logic [31:0] adat_o;
    logic        en;
    logic [3:0]  bwe;
    logic [31:0] badr, bdat, brd;
    logic [1:0]  grant;
    logic        acc_req3;
    logic [31:0] acc_adr3;
    logic        wack3, aack3, en3;
    logic [31:0] wdat3, adat3, badr3, bdat3, brd3;
    logic [3:0]  bwe3;
    logic [1:0]  grant3;
    logic        z1;
    logic [3:0]  z4;
    logic [31:0] z32;
    logic [31:0] mem [0:15];
    int compared = 0, mismatched = 0;

    bram_arbiter #(.DELAYS(1)) u1 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(wack), .wbs_dat_o(wdat_o),
        .acc_req_i(acc_req), .acc_we_i(acc_we), .acc_sel_i(acc_sel),
        .acc_adr_i(acc_adr), .acc_dat_i(acc_dat), .acc_ack_o(aack), .acc_dat_o(adat_o),
        .bram_en_o(en), .bram_we_o(bwe), .bram_adr_o(badr), .bram_dat_o(bdat),
        .bram_dat_i(brd), .grant_o(grant)
    );

    bram_arbiter #(.DELAYS(3)) u3 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(z1), .wbs_stb_i(z1), .wbs_we_i(z1), .wbs_sel_i(z4),
        .wbs_adr_i(z32), .wbs_dat_i(z32), .wbs_ack_o(wack3), .wbs_dat_o(wdat3),
        .acc_req_i(acc_req3), .acc_we_i(z1), .acc_sel_i(z4),
        .acc_adr_i(acc_adr3), .acc_dat_i(z32), .acc_ack_o(aack3), .acc_dat_o(adat3),
        .bram_en_o(en3), .bram_we_o(bwe3), .bram_adr_o(badr3), .bram_dat_o(bdat3),
        .bram_dat_i(brd3), .grant_o(grant3)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    assign brd  = mem[badr[5:2]];
    assign brd3 = {badr3[15:0], 16'hC0DE};
    always @(posedge clk)
        if (en)
            for (int b = 0; b < 4; b++)
                if (bwe[b]) mem[badr[5:2]][8*b +: 8] <= bdat[8*b +: 8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic is_acc, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output int lat, output int en_cnt);
        logic got;
        @(negedge clk);
        if (is_acc) begin
            acc_req = 1; acc_we = w; acc_sel = s; acc_adr = a; acc_dat = d;
        end else begin
            cyc = 1; stb = 1; we = w; sel = s; adr = a; dat = d;
        end
        lat = 0; en_cnt = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            en_cnt += int'(en);
            got = is_acc ? aack : wack;
        end while (!got && lat < 20);
        rd = is_acc ? adat_o : wdat_o;
        @(negedge clk);
        acc_req = 0; cyc = 0; stb = 0;
    endtask

    task automatic txn3(input logic [31:0] a, output logic [31:0] rd,
                        output int lat, output int en_cnt, output logic [1:0] g);
        @(negedge clk);
        acc_req3 = 1; acc_adr3 = a;
        lat = 0; en_cnt = 0; g = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            en_cnt += int'(en3);
            if (lat == 1) g = grant3;
        end while (!aack3 && lat < 20);
        rd = adat3;
        @(negedge clk);
        acc_req3 = 0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  seq, seq_exp;
        logic [1:0]  g;
        logic        any;
        int lat, ec, k, n;
        rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0;
        acc_req = 0; acc_we = 0; acc_sel = 0; acc_adr = 0; acc_dat = 0;
        acc_req3 = 0; acc_adr3 = 0; z1 = 0; z4 = 0; z32 = 0;
        #1;
        chk("rst_en", {31'd0, en}, 0);
        chk("rst_we", {28'd0, bwe}, 0);
        chk("rst_grant", {30'd0, grant}, 0);
        chk("rst_acks", {30'd0, wack, aack}, 0);
        chk("rst_adr", badr, 0);
        chk("rst_rdata", wdat_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0;

        txn(0, 1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, rd, lat, ec);
        chk("wr_lat", lat, 2);
        chk("wr_en_cycles", ec, 1);
        txn(0, 0, 4'hF, 32'h3800_0010, 32'h0, rd, lat, ec);
        chk("rd_lat", lat, 2);
        chk("rd_data", rd, 32'hDEAD_BEEF);

        txn(0, 1, 4'hF, 32'h3800_0014, 32'h1122_3344, rd, lat, ec);
        txn(0, 1, 4'b0010, 32'h3800_0014, 32'h0000_AB00, rd, lat, ec);
        txn(0, 0, 4'hF, 32'h3800_0014, 32'h0, rd, lat, ec);
        chk("byte_wr", rd, 32'h1122_AB44);

        txn(1, 1, 4'b1000, 32'h3800_0010, 32'h5500_0000, rd, lat, ec);
        chk("acc_wr_lat", lat, 2);
        txn(1, 0, 4'hF, 32'h3800_0010, 32'h0, rd, lat, ec);
        chk("acc_rd_data", rd, 32'h55AD_BEEF);

        @(negedge clk);
        cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 32'h3000_0000;
        any = 0;
        repeat (6) begin
            @(posedge clk); #1;
            any |= en | wack | (grant != 0);
        end
        chk("nodecode", {31'd0, any}, 0);
        @(negedge clk); cyc = 0; stb = 0;

        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 32'h3800_0010;
        @(posedge clk); #1;
        chk("abort_en", {31'd0, en}, 1);
        @(negedge clk); cyc = 0; stb = 0;
        any = 0;
        repeat (4) begin
            @(posedge clk); #1;
            any |= wack;
        end
        chk("abort_noack", {31'd0, any}, 0);
        txn(0, 0, 4'hF, 32'h3800_0014, 32'h0, rd, lat, ec);
        chk("post_abort", rd, 32'h1122_AB44);

        txn3(32'h3800_0044, rd, lat, ec, g);
        chk("d3_lat", lat, 4);
        chk("d3_en_cycles", ec, 3);
        chk("d3_data", rd, 32'h0044_C0DE);
        chk("d3_grant", {30'd0, g}, 32'd2);

        @(negedge clk);
        acc_req3 = 1; acc_adr3 = 32'h3800_0048;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_en", {31'd0, en3}, 1);
        rst = 1;
        #1;
        chk("arst_en", {31'd0, en3}, 0);
        chk("arst_grant", {30'd0, grant3}, 0);
        chk("arst_ack", {31'd0, aack3}, 0);
        @(negedge clk); acc_req3 = 0;
        @(negedge clk); rst = 0;
        any = 0;
        repeat (6) begin
            @(posedge clk); #1;
            any |= aack3 | en3;
        end
        chk("arst_noack", {31'd0, any}, 0);
        txn3(32'h3800_0048, rd, lat, ec, g);
        chk("arst_next_lat", lat, 4);
        chk("arst_next_data", rd, 32'h0048_C0DE);

`ifdef BRAM_ARB_RR_EN
        seq_exp = 8'b01_10_01_10;
`else
        seq_exp = 8'b01_01_01_01;
`endif
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 32'h3800_0010;
        acc_req = 1; acc_we = 0; acc_adr = 32'h3800_0014;
        k = 0; n = 0; seq = 0;
        while (k < 4 && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) chk("tie_grant0", {30'd0, grant}, 32'd1);
            if (wack | aack) begin
                seq = {seq[5:0], aack, wack};
                k++;
            end
        end
        chk("tie_order", {24'd0, seq}, {24'd0, seq_exp});
        @(negedge clk); cyc = 0; stb = 0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(wack | aack) && n < 20);
        chk("tie_tail", {30'd0, aack, wack}, 32'd2);
        @(negedge clk); acc_req = 0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-requester access controller for the shared user-area BRAM. Arbitrates between the management Wishbone slave port and an on-chip accelerator/DMA request port. Sequences each granted access through a fixed-latency BRAM (enable, wait DELAYS cycles, capture), then returns a single-cycle acknowledge to the winner. Sits inside the user project wrapper between the Wishbone decode and the `bram` instance, and replaces the wrapper's free-running delay counter.

## Interface
Parameters:
- `DELAYS`, 1, BRAM read latency in cycles; legal range 1..15
- `ADDR_BASE`, 12'h380, value of `wbs_adr_i[31:20]` that selects the BRAM

Ports:
- `wb_clk_i`  in  1  single clock for all state
- `wb_rst_i`  in  1  reset, asynchronous, active-high
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone request from the management core
- `wbs_sel_i`  in  4  Wishbone byte enables
- `wbs_adr_i`  in  32  Wishbone byte address
- `wbs_dat_i`  in  32  Wishbone write data
- `wbs_ack_o`  out  1  Wishbone acknowledge, one-cycle pulse
- `wbs_dat_o`  out  32  Wishbone read data; valid while `wbs_ack_o` is high
- `acc_req_i`, `acc_we_i`  in  1 each  accelerator request and write flag
- `acc_sel_i`  in  4  accelerator byte enables
- `acc_adr_i`  in  32  accelerator byte address
- `acc_dat_i`  in  32  accelerator write data
- `acc_ack_o`  out  1  accelerator acknowledge, one-cycle pulse
- `acc_dat_o`  out  32  accelerator read data; valid while `acc_ack_o` is high
- `bram_en_o`  out  1  BRAM enable
- `bram_we_o`  out  4  BRAM byte write strobes
- `bram_adr_o`  out  32  BRAM address
- `bram_dat_o`  out  32  BRAM write data
- `bram_dat_i`  in  32  BRAM read data
- `grant_o`  out  2  current owner, one-hot: bit0 = Wishbone, bit1 = accelerator; 0 when idle

## Operation
Request qualification:
- Wishbone request: `wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20] == ADDR_BASE)`.
- Non-decoded Wishbone cycles are ignored and `wbs_ack_o` stays 0; the wrapper muxes other slaves.
- Accelerator request: `acc_req_i`.

State machine (IDLE, ACCESS, ACK):
- IDLE to ACCESS when any request is present; the winner is chosen in the same cycle.
- On that edge the winner's address, write data, and strobes are latched into command registers: `bram_we_o = sel & {4{we}}`.
- ACCESS: `bram_en_o` = 1 and `bram_*_o` driven from the command registers. Counter `cnt` runs 0..DELAYS-1.
- When `cnt == DELAYS-1`, `bram_dat_i` is captured into the read-data register and the state goes to ACK.
- ACK: exactly one of `wbs_ack_o` / `acc_ack_o` = 1 for one cycle, read data presented, `bram_en_o` = 0. Next state is always IDLE, and the last-grant pointer updates here.
- Requesters must drop their request in the cycle after the ack. A request still present in IDLE is treated as a new access.

Other behaviour:
- Writes are committed to BRAM during ACCESS; the write ack carries don't-care data.
- Wishbone abort (`wbs_cyc_i` falls during ACCESS): the access still completes to BRAM, and `wbs_ack_o` is gated by `wbs_cyc_i` and suppressed. No retry.
- Both outputs `wbs_dat_o` and `acc_dat_o` are driven from the shared read-data register.

## Timing
- Reset values: state = IDLE, `cnt` = 0, all acks 0, `bram_en_o` = 0, `bram_we_o` = 0, `grant_o` = 0, data and command registers 0, last-grant pointer = accelerator (so Wishbone wins first).
- Latency: a request present at edge E0 gives `bram_en_o` high during cycles E0..E0+DELAYS, and ack high during the cycle after edge E0+DELAYS.
- Throughput: one access per DELAYS+2 cycles.
- A reset asserted in any state takes effect immediately (asynchronously): ack and enable drop, and no ack is ever issued for the interrupted access.
- Simultaneous requests: resolved as described under Configuration.
- `bram_adr_o` and `bram_dat_o` are stable for the whole of ACCESS, even if requester inputs change.

## Configuration
- `BRAM_ARB_RR_EN` defined: round-robin arbitration. On a tie, the requester not granted last wins, so the grants alternate.
- `BRAM_ARB_RR_EN` undefined: fixed priority, Wishbone always wins a tie. The pointer register is omitted.
- Single-requester behaviour is identical in both builds.

## Test plan
- Wishbone write 0xDEADBEEF, sel 4'hF, to 0x3800_0010, then read back with DELAYS = 1:
  - each ack arrives 2 cycles after the request edge;
  - the read returns 0xDEADBEEF.
- Byte write, sel 4'b0010, data 0x0000_AB00 over 0x1122_3344, then read:
  - the read returns 0x1122_AB44.
- Simultaneous Wishbone and accelerator reads held for 4 accesses:
  - with `BRAM_ARB_RR_EN`: grants go WB, ACC, WB, ACC;
  - without it: WB wins every tie, and ACC is served only once WB is idle.
- Wishbone access to 0x3000_0000: no `bram_en_o`, `wbs_ack_o` stays 0, and `grant_o` stays 0.
- DELAYS = 3 accelerator read: `bram_en_o` is high for 3 cycles, and `acc_ack_o` comes 4 cycles after the request edge with the captured data.
- Assert `wb_rst_i` during ACCESS: outputs go to reset values immediately, there is no ack afterwards, and the next request is served normally.
